// File: rtl/ram_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_arbiter_if : host, fabric and RAM-side signals of ram_arbiter     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface ram_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) ();
  logic                  host_req_i;
  logic                  host_we_i;
  logic [ADDR_WIDTH-1:0] host_addr_i;
  logic [DATA_WIDTH-1:0] host_data_i;
  logic [DATA_WIDTH-1:0] host_data_o;
  logic                  host_ack_o;

  logic                  fab_req_i;
  logic                  fab_we_i;
  logic [ADDR_WIDTH-1:0] fab_addr_i;
  logic [DATA_WIDTH-1:0] fab_data_i;
  logic [DATA_WIDTH-1:0] fab_data_o;
  logic                  fab_ack_o;

  logic                  ram_rd_o;
  logic                  ram_wr_o;
  logic [ADDR_WIDTH-1:0] ram_addr_o;
  logic [DATA_WIDTH-1:0] ram_data_o;
  logic [DATA_WIDTH-1:0] ram_data_i;

  logic                  busy_o;
  logic                  owner_o;

  // Arbiter side
  modport slave (
    input  host_req_i, host_we_i, host_addr_i, host_data_i,
    output host_data_o, host_ack_o,
    input  fab_req_i, fab_we_i, fab_addr_i, fab_data_i,
    output fab_data_o, fab_ack_o,
    output ram_rd_o, ram_wr_o, ram_addr_o, ram_data_o,
    input  ram_data_i,
    output busy_o, owner_o
  );

  // Requester / RAM side
  modport master (
    output host_req_i, host_we_i, host_addr_i, host_data_i,
    input  host_data_o, host_ack_o,
    output fab_req_i, fab_we_i, fab_addr_i, fab_data_i,
    input  fab_data_o, fab_ack_o,
    input  ram_rd_o, ram_wr_o, ram_addr_o, ram_data_o,
    output ram_data_i,
    input  busy_o, owner_o
  );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_arbiter : host-priority arbiter and 4-state access sequencer for  |
// |               a single-port registered-read RAM. Rev 1.0             |
// +----------------------------------------------------------------------+
module ram_arbiter #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  wire logic     clk_i,
  input  wire logic     reset_i,
  ram_arbiter_if.slave  bus
);

  localparam int                 c_CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [c_CNT_W-1:0]    r_cnt;
  logic                  r_owner;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_host_data;
  logic [DATA_WIDTH-1:0] r_fab_data;
  logic                  r_host_ack;
  logic                  r_fab_ack;
  logic                  r_rd;
  logic                  r_wr;
  logic                  r_busy;

  logic                  w_fab_grant;
  logic                  w_host_grant;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;

  // Fabric wins when the host is quiet or has used up its consecutive-grant budget
  assign w_fab_grant  = bus.fab_req_i && (!bus.host_req_i || (r_cnt == c_LIMIT));
  assign w_host_grant = bus.host_req_i && !w_fab_grant;
  assign w_sel_we     = w_fab_grant ? bus.fab_we_i   : bus.host_we_i;
  assign w_sel_addr   = w_fab_grant ? bus.fab_addr_i : bus.host_addr_i;
  assign w_sel_data   = w_fab_grant ? bus.fab_data_i : bus.host_data_i;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_owner     <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_host_data <= '0;
      r_fab_data  <= '0;
      r_host_ack  <= 1'b0;
      r_fab_ack   <= 1'b0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_host_ack <= 1'b0;
      r_fab_ack  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fab_grant || w_host_grant) begin
            r_state <= S_ISSUE;
            r_busy  <= 1'b1;
            r_owner <= w_fab_grant;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_data;
            r_rd    <= !w_sel_we;
            r_wr    <= w_sel_we;
          end
          if (w_fab_grant || !bus.fab_req_i) begin
            r_cnt <= '0;
          end else if (w_host_grant && (r_cnt != c_LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_state <= S_DONE;
          // RAM output is valid here, one edge after the read strobe was sampled
          if (!r_we) begin
            if (r_owner) begin
              r_fab_data <= bus.ram_data_i;
            end else begin
              r_host_data <= bus.ram_data_i;
            end
          end
          r_host_ack <= !r_owner;
          r_fab_ack  <= r_owner;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.host_data_o = r_host_data;
  assign bus.host_ack_o  = r_host_ack;
  assign bus.fab_data_o  = r_fab_data;
  assign bus.fab_ack_o   = r_fab_ack;
  assign bus.ram_rd_o    = r_rd;
  assign bus.ram_wr_o    = r_wr;
  assign bus.ram_addr_o  = r_addr;
  assign bus.ram_data_o  = r_wdata;
  assign bus.busy_o      = r_busy;
  assign bus.owner_o     = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ram_arbiter : directed table, corner sequences and random traffic |
// |                  against a transaction-phase reference model. Rev 1.0|
// +----------------------------------------------------------------------+
module tb_ram_arbiter;
  localparam int DW = 16;
  localparam int AW = 5;
  localparam int SL = 4;

  logic clk_i   = 1'b0;
  logic reset_i = 1'b0;
  logic init_en = 1'b1;
  always #5 clk_i = ~clk_i;

  ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  // RAM device: registered read, write on the strobe edge
  logic [DW-1:0] ram [32];
  logic [DW-1:0] ram_q;
  always @(posedge clk_i) begin
    if (init_en) begin
      for (int i = 0; i < 32; i++) ram[i] <= '0;
      ram_q <= '0;
    end else begin
      if (bus.ram_wr_o) ram[bus.ram_addr_o] <= bus.ram_data_o;
      if (bus.ram_rd_o) ram_q <= ram[bus.ram_addr_o];
    end
  end
  assign bus.ram_data_i = ram_q;

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 = idle, 1..3 = cycles since the grant edge
  logic [DW-1:0] m_mem [32];
  int            m_phase;
  int            m_cnt;
  logic          m_owner, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, e_hdata, e_fdata;

  bit   g_q [$];
  logic prev_busy;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_owner = 0; m_we = 0;
    m_addr = '0; m_wdata = '0; e_hdata = '0; e_fdata = '0;
  endtask

  task automatic model_edge();
    bit fg, hg;
    if (!reset_i) begin
      model_reset();
      return;
    end
    if (m_phase == 0) begin
      fg = bus.fab_req_i && (!bus.host_req_i || m_cnt >= SL);
      hg = bus.host_req_i && !fg;
      if (fg || !bus.fab_req_i) m_cnt = 0;
      else if (hg) m_cnt = (m_cnt < SL) ? m_cnt + 1 : SL;
      if (fg || hg) begin
        m_owner = fg;
        m_we    = fg ? bus.fab_we_i   : bus.host_we_i;
        m_addr  = fg ? bus.fab_addr_i : bus.host_addr_i;
        m_wdata = fg ? bus.fab_data_i : bus.host_data_i;
        m_phase = 1;
      end
    end else begin
      if (m_phase == 1 && m_we) m_mem[m_addr] = m_wdata;
      if (m_phase == 2 && !m_we) begin
        if (m_owner) e_fdata = m_mem[m_addr];
        else         e_hdata = m_mem[m_addr];
      end
      m_phase = (m_phase + 1) % 4;
    end
  endtask

  function automatic logic [63:0] act_vec();
    return {5'b0, bus.busy_o, bus.owner_o, bus.ram_rd_o, bus.ram_wr_o,
            bus.host_ack_o, bus.fab_ack_o, bus.ram_addr_o, bus.ram_data_o,
            bus.host_data_o, bus.fab_data_o};
  endfunction

  function automatic logic [63:0] exp_vec();
    return {5'b0, m_phase != 0, m_owner, m_phase == 1 && !m_we, m_phase == 1 && m_we,
            m_phase == 3 && !m_owner, m_phase == 3 && m_owner, m_addr, m_wdata,
            e_hdata, e_fdata};
  endfunction

  task automatic step();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
    check("cycle", act_vec(), exp_vec());
    if (bus.busy_o && !prev_busy) g_q.push_back(bus.owner_o);
    prev_busy = bus.busy_o;
  endtask

  task automatic idle_inputs();
    bus.host_req_i = 0; bus.host_we_i = 0; bus.host_addr_i = '0; bus.host_data_i = '0;
    bus.fab_req_i  = 0; bus.fab_we_i  = 0; bus.fab_addr_i  = '0; bus.fab_data_i  = '0;
  endtask

  typedef struct {
    bit            fab;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] expd;
  } txn_t;

  task automatic txn(txn_t t);
    int  n = 0, rds = 0, wrs = 0, other_ack = 0;
    bit  got = 0;
    if (t.fab) begin
      bus.fab_req_i = 1; bus.fab_we_i = t.we; bus.fab_addr_i = t.addr; bus.fab_data_i = t.data;
    end else begin
      bus.host_req_i = 1; bus.host_we_i = t.we; bus.host_addr_i = t.addr; bus.host_data_i = t.data;
    end
    while (!got && n < 20) begin
      step();
      n++;
      rds += int'(bus.ram_rd_o);
      wrs += int'(bus.ram_wr_o);
      other_ack += int'(t.fab ? bus.host_ack_o : bus.fab_ack_o);
      if (t.fab ? bus.fab_ack_o : bus.host_ack_o) begin
        got = 1;
        if (t.fab) bus.fab_req_i = 0; else bus.host_req_i = 0;
      end
    end
    check("txn_latency", 64'(n), 64'd3);
    check("txn_strobes", {32'(rds), 32'(wrs)}, {32'(!t.we), 32'(t.we)});
    check("txn_other_ack", 64'(other_ack), 64'd0);
    if (!t.we) check("txn_rdata", t.fab ? bus.fab_data_o : bus.host_data_o, t.expd);
    step();
  endtask

  txn_t tbl [10];
  bit   exp_sim [10];
  bit   exp_clr [9];

  initial begin
    int n, both, acks;
    bit h_act, f_act;

    tbl[0] = '{0, 1, 5'd3,  16'hBEEF, 16'h0000};
    tbl[1] = '{0, 0, 5'd3,  16'h0000, 16'hBEEF};
    tbl[2] = '{1, 1, 5'd31, 16'h1234, 16'h0000};
    tbl[3] = '{1, 0, 5'd31, 16'h0000, 16'h1234};
    tbl[4] = '{0, 1, 5'd5,  16'h5555, 16'h0000};
    tbl[5] = '{0, 1, 5'd9,  16'h9999, 16'h0000};
    tbl[6] = '{1, 0, 5'd5,  16'hFFFF, 16'h5555};
    tbl[7] = '{0, 0, 5'd31, 16'h0000, 16'h1234};
    tbl[8] = '{1, 1, 5'd0,  16'hA5A5, 16'h0000};
    tbl[9] = '{0, 0, 5'd0,  16'h0000, 16'hA5A5};
    exp_sim = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    exp_clr = '{0, 0, 0, 0, 0, 0, 0, 0, 1};

    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    idle_inputs();
    model_reset();
    prev_busy = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    init_en = 0;
    check("reset_state", act_vec(), 64'd0);
    reset_i = 1;
    step();

    for (int i = 0; i < 10; i++) txn(tbl[i]);

    // Address and req change after the grant must not disturb the transaction
    bus.host_req_i = 1; bus.host_we_i = 0; bus.host_addr_i = 5'd5;
    step();
    bus.host_req_i = 0; bus.host_addr_i = 5'd9; bus.host_data_i = 16'h7777; bus.host_we_i = 1;
    step();
    check("mid_addr_hold", 64'(bus.ram_addr_o), 64'd5);
    n = 0; acks = 0;
    while (acks == 0 && n < 10) begin step(); n++; acks += int'(bus.host_ack_o); end
    check("mid_ack", 64'(acks), 64'd1);
    check("mid_data", 64'(bus.host_data_o), 64'h5555);
    step();
    idle_inputs();

    // Reset asserted while the read is in WAIT
    bus.host_req_i = 1; bus.host_addr_i = 5'd9;
    step();
    bus.host_req_i = 0;
    step();
    reset_i = 0;
    #1;
    check("rst_mid_outputs", {bus.busy_o, bus.ram_rd_o, bus.ram_wr_o, bus.host_ack_o, bus.fab_ack_o}, 64'd0);
    model_reset();
    step(); step();
    reset_i = 1;
    acks = 0;
    repeat (6) begin step(); acks += int'(bus.host_ack_o) + int'(bus.fab_ack_o); end
    check("rst_mid_no_ack", 64'(acks), 64'd0);

    // Fabric pulses while the host is quiet: granted on the first sample
    for (int i = 0; i < 3; i++) begin
      bus.fab_req_i = 1; bus.fab_we_i = 0; bus.fab_addr_i = 5'(i * 3);
      step();
      bus.fab_req_i = 0;
      check("fab_first_grant", {bus.busy_o, bus.owner_o}, 64'b11);
      repeat (3) step();
      bus.host_req_i = 1; bus.host_addr_i = 5'd3;
      step();
      bus.host_req_i = 0;
      repeat (3) step();
    end

    // Both requesting continuously
    g_q.delete();
    bus.host_req_i = 1; bus.host_we_i = 0; bus.host_addr_i = 5'd3;
    bus.fab_req_i  = 1; bus.fab_we_i  = 0; bus.fab_addr_i  = 5'd31;
    n = 0; both = 0;
    while (g_q.size() < 10 && n < 80) begin
      step(); n++;
      both += int'(bus.host_ack_o && bus.fab_ack_o);
    end
    check("sim_grant_count", 64'(g_q.size()), 64'd10);
    check("sim_both_acks", 64'(both), 64'd0);
    for (int i = 0; i < 10 && i < g_q.size(); i++) check("sim_grant", 64'(g_q[i]), 64'(exp_sim[i]));
    idle_inputs();
    repeat (4) step();

    // One IDLE arbitration without fab_req clears the starvation count
    g_q.delete();
    bus.host_req_i = 1;
    n = 0;
    while (g_q.size() < 9 && n < 100) begin
      bus.fab_req_i = (g_q.size() != 3);
      step(); n++;
    end
    check("clr_grant_count", 64'(g_q.size()), 64'd9);
    for (int i = 0; i < 9 && i < g_q.size(); i++) check("clr_grant", 64'(g_q[i]), 64'(exp_clr[i]));
    idle_inputs();
    repeat (4) step();

    // Random traffic following the request/ack protocol
    h_act = 0; f_act = 0;
    repeat (1500) begin
      if (h_act && m_phase == 3 && !m_owner) begin
        h_act = 0; bus.host_req_i = 0;
      end else if (h_act) begin
        bus.host_addr_i = 5'($urandom_range(0, 7)); bus.host_data_i = 16'($urandom);
      end else if ($urandom_range(0, 3) == 0) begin
        h_act = 1; bus.host_req_i = 1; bus.host_we_i = 1'($urandom);
        bus.host_addr_i = 5'($urandom_range(0, 7)); bus.host_data_i = 16'($urandom);
      end
      if (f_act && m_phase == 3 && m_owner) begin
        f_act = 0; bus.fab_req_i = 0;
      end else if (f_act) begin
        bus.fab_addr_i = 5'($urandom_range(0, 7)); bus.fab_data_i = 16'($urandom);
      end else if ($urandom_range(0, 3) == 0) begin
        f_act = 1; bus.fab_req_i = 1; bus.fab_we_i = 1'($urandom);
        bus.fab_addr_i = 5'($urandom_range(0, 7)); bus.fab_data_i = 16'($urandom);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
